// File: rtl/uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_transmitter: 8-bit UART serializer, optional parity, 1/2 stop bits,  |
// | one-entry holding register for back-to-back frames.  Rev 1.0               |
// +----------------------------------------------------------------------------+
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       rdy,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int                BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] c_BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        c_STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit                c_HAS_PARITY = (PARITY != 0);
    localparam bit                c_ODD        = (PARITY == 2);

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_par;
    logic [7:0]        r_hold;
    logic              r_hold_full;

    logic w_accept;
    logic w_bit_end;
    logic w_frame_end;
    logic w_load;

    assign rdy         = en & ~r_hold_full;
    assign w_accept    = valid & rdy;
    assign w_bit_end   = (r_baud == c_BAUD_LAST);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit == c_STOP_LAST);
    // Accept and load are mutually exclusive: one needs the holder empty, the other full.
    assign w_load      = r_hold_full && ((r_state == S_IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (w_accept) begin
                r_hold      <= data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (r_state != S_IDLE) begin
                r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
            end

            if (w_load) begin
                r_state <= S_START;
                r_shift <= r_hold;
                r_par   <= (^r_hold) ^ c_ODD;
                r_baud  <= '0;
                r_bit   <= '0;
                tx      <= 1'b0;
                busy    <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_hold_full) begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        tx      <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd7) begin
                            r_bit <= '0;
                            if (c_HAS_PARITY) begin
                                r_state <= S_PARITY;
                                tx      <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                tx      <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_bit   <= '0;
                        tx      <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit == c_STOP_LAST) begin
                            done <= 1'b1;
                            if (!r_hold_full) begin
                                r_state <= S_IDLE;
                                tx      <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_transmitter: scoreboard bench over four transmitter configs.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] valid;
    logic [7:0] data;
    logic [3:0] rdy;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;

    always #5 clk = ~clk;

    // dut0: defaults, dut1: even parity + 2 stop, dut2: odd parity + 2 stop, dut3: 4 clks/bit
    uart_transmitter #(.CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .valid(valid[0]), .data(data),
        .rdy(rdy[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_transmitter #(.CLKS_PER_BIT(1), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .valid(valid[1]), .data(data),
        .rdy(rdy[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_transmitter #(.CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .valid(valid[2]), .data(data),
        .rdy(rdy[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));
    uart_transmitter #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .valid(valid[3]), .data(data),
        .rdy(rdy[3]), .tx(tx[3]), .busy(busy[3]), .done(done[3]));

    typedef struct packed {
        logic [1:0] k;
        logic       bitv;
        logic       last;
        logic       b2b;
    } exp_t;

    exp_t       q[$];
    logic [3:0] pend_done = '0;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check(input string name, input int k, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %b expected %b at %0t", name, k, act, exp, $time);
        end
    endtask

    // bits[0] is the start bit; each bit is repeated cpb times on the line.
    task automatic push_frame(input int k, input logic [11:0] bits, input int nb,
                              input int cpb, input bit b2b, input bit complete);
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < cpb; j++) begin
                q.push_back('{k: 2'(k), bitv: bits[i],
                              last: complete && (i == nb - 1) && (j == cpb - 1),
                              b2b: b2b && (i == 0) && (j == 0)});
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] b);
        check("rdy_before_accept", k, rdy[k], 1'b1);
        data     = b;
        valid[k] = 1'b1;
        tick(1);
        valid[k] = 1'b0;
    endtask

    // Monitor: every busy cycle must match the next expected line bit of that DUT.
    always @(negedge clk) begin
        logic [3:0] nd;
        exp_t       e;
        nd = '0;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (pend_done[k] || done[k])
                    check("done_pulse", k, done[k], pend_done[k]);
                if (pend_done[k] && q.size() > 0 && q[0].k == 2'(k) && q[0].b2b)
                    check("no_idle_gap", k, busy[k], 1'b1);
                if (busy[k]) begin
                    if (q.size() > 0 && q[0].k == 2'(k)) begin
                        e = q.pop_front();
                        check("tx_bit", k, tx[k], e.bitv);
                        nd[k] = e.last;
                    end else begin
                        check("unexpected_busy", k, busy[k], 1'b0);
                    end
                end
            end
        end
        pend_done <= nd;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        valid = 4'hF;
        data  = 8'hC3;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            check("reset_tx", k, tx[k], 1'b1);
            check("reset_busy", k, busy[k], 1'b0);
            check("reset_done", k, done[k], 1'b0);
            check("reset_rdy", k, rdy[k], 1'b1);
        end
        tick(1);
        rst   = 1'b0;
        valid = 4'h0;
        tick(5);
        check("no_frame_after_reset", 0, busy[0], 1'b0);

        // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1
        send(0, 8'hA5);
        push_frame(0, 12'b00_1_10100101_0, 10, 1, 1'b0, 1'b1);
        check("rdy_load_cycle", 0, rdy[0], 1'b0);
        tick(1);
        check("start_latency_tx", 0, tx[0], 1'b0);
        check("start_latency_busy", 0, busy[0], 1'b1);
        check("rdy_during_frame", 0, rdy[0], 1'b1);
        tick(15);

        // Back-to-back 0x00 then 0xFF, second accepted during DATA
        send(0, 8'h00);
        push_frame(0, 12'b00_1_00000000_0, 10, 1, 1'b0, 1'b1);
        tick(3);
        send(0, 8'hFF);
        push_frame(0, 12'b00_1_11111111_0, 10, 1, 1'b1, 1'b1);
        check("rdy_after_second_accept", 0, rdy[0], 1'b0);
        tick(4);
        check("rdy_hold_full_mid", 0, rdy[0], 1'b0);
        tick(2);
        check("rdy_hold_full_end", 0, rdy[0], 1'b0);
        tick(1);
        check("rdy_after_second_load", 0, rdy[0], 1'b1);
        tick(15);

        // Parity 0x07: even -> 1, odd -> 0, two stop bits
        send(1, 8'h07);
        push_frame(1, 12'b11_1_00000111_0, 12, 1, 1'b0, 1'b1);
        tick(16);
        send(2, 8'h07);
        push_frame(2, 12'b11_0_00000111_0, 12, 1, 1'b0, 1'b1);
        tick(16);

        // Baud: 4 clks per bit, 40-cycle frame
        send(3, 8'h01);
        push_frame(3, 12'b00_1_00000001_0, 10, 4, 1'b0, 1'b1);
        tick(45);

        // Abort during data bit 3 with a second byte buffered
        send(0, 8'h3C);
        push_frame(0, 12'b0000000_11000, 5, 1, 1'b0, 1'b0);
        tick(1);
        send(0, 8'h55);
        check("rdy_second_buffered", 0, rdy[0], 1'b0);
        tick(3);
        en = 1'b0;
        tick(1);
        check("abort_tx", 0, tx[0], 1'b1);
        check("abort_busy", 0, busy[0], 1'b0);
        check("abort_rdy", 0, rdy[0], 1'b0);
        check("abort_bits_consumed", 0, (q.size() == 0), 1'b1);
        en = 1'b1;
        tick(20);
        check("no_replay_busy", 0, busy[0], 1'b0);
        check("rdy_after_reenable", 0, rdy[0], 1'b1);

        check("queue_drained", 0, (q.size() == 0), 1'b1);
        check("no_pending_done", 0, (pend_done == 4'h0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serializes bytes onto a UART line: start bit (0), 8 data bits LSB first, optional parity, 1 or 2 stop bits (1). It is the transmit-side counterpart of the UART receiver in the bringup UART path. Default timing is one bit per clk, matching the receiver's one-sample-per-clock operation so both can be looped back directly. A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
CLKS_PER_BIT, 1, clk cycles per serial bit; legal range 1..65535.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
en  input  1  transmitter enable; low aborts and holds the line idle.
valid  input  1  data holds a byte to send.
data  input  8  byte to transmit.
rdy  output  1  holding register can accept a byte.
tx  output  1  serial line out; idles high.
busy  output  1  a frame is on the line.
done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (rst high at posedge): tx=1, busy=0, done=0, holding register empty, state IDLE, bit and baud counters 0. rst overrides en and valid.
- rdy = en & ~hold_full. This is combinational from registered state.
- Accept: a byte is taken at a posedge with valid & rdy. The byte is latched into the holding register and hold_full is set. valid without rdy is ignored, and the byte is not queued.
- States:
  - IDLE: tx=1.
  - START, DATA, PARITY, STOP: each bit is held CLKS_PER_BIT cycles by the baud counter.
- IDLE -> START: on the posedge where the state is IDLE and hold_full=1. The shifter loads from the holding register, hold_full clears, and tx goes 0 and busy goes 1 at that same edge.
- Latency: a byte accepted at edge N into an idle transmitter gives tx=0 from edge N+1.
- DATA: 8 bits, LSB first. The bit counter runs 0..7.
- PARITY: skipped when PARITY=0. Even parity is XOR of the 8 bits. Odd parity is its inverse.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: (9 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- End of the last stop cycle:
  - done pulses high for 1 cycle.
  - If hold_full, go directly to START with the next byte, with no idle cycle. busy stays 1.
  - Otherwise go to IDLE and busy=0.
- Accept during a frame: permitted whenever hold_full=0. rdy therefore stays high through the first frame until a second byte is buffered.
- Accept and shifter load on the same edge, from IDLE: the holding register cannot be both loaded and drained in one edge. Load takes priority over accept, and rdy is 0 in that cycle because hold_full=1.
- en low at any posedge (rst low): abort immediately.
  - State goes to IDLE, tx=1, busy=0, hold_full cleared (byte discarded), done=0.
  - Resuming en does not replay the discarded byte.
- Counters are sized from CLKS_PER_BIT. No wrap occurs other than the intended reload to 0 at each bit boundary.

Test Plan:
- Reset: assert rst 2 cycles with valid=1 -> tx=1, busy=0, done=0, rdy=1 (en=1), no frame starts.
- Single byte, defaults: send 0xA5 -> from the next edge tx = 0,1,0,1,0,0,1,0,1,1, then idle 1. busy high for 10 cycles; done pulses on the cycle after the stop bit. Looped into the receiver with en=1, the receiver presents data=0xA5 with rdy=1.
- Back-to-back: present 0x00 then 0xFF, the second while the first is in DATA -> 20 consecutive frame cycles with no idle between frames. rdy is low from the second accept until the second byte loads.
- Parity, PARITY=1, STOP_BITS=2: send 0x07 -> parity bit 1, stop 1,1, 12-cycle frame. PARITY=2 gives parity bit 0.
- Baud: CLKS_PER_BIT=4, send 0x01 -> each bit lasts exactly 4 cycles, 40-cycle frame, done exactly 40 cycles after the start edge.
- Abort: drop en during data bit 3 with a second byte buffered -> tx=1 at the next edge, busy=0, rdy=0. Re-enabling produces no frame until a new accept.
